// File: rtl/vec_result_fifo_pkg.sv
// Shared types and constants for the vec_mul result path.
//   FMUL_LATENCY : vec_mul input->result latency in cycles
//   VEC_SIZE     : default float width per vector component
//   vec3_t       : three packed components, index 0 = x
package vec_result_fifo_pkg;

    localparam int unsigned FMUL_LATENCY = 9;
    localparam int unsigned VEC_SIZE     = 32;

    typedef logic [2:0][VEC_SIZE-1:0] vec3_t;

    function automatic vec3_t make_vec3(input logic [VEC_SIZE-1:0] x,
                                        input logic [VEC_SIZE-1:0] y,
                                        input logic [VEC_SIZE-1:0] z);
        vec3_t v;
        v[0] = x;
        v[1] = y;
        v[2] = z;
        return v;
    endfunction

    function automatic bit is_pow2(input int unsigned n);
        return (n != 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/vec_result_fifo_if.sv
// AXI-stream style vector channel.
//   tdata  : three SIZE-bit components
//   tvalid : source has a beat
//   tready : sink accepts the beat
// master drives tdata/tvalid, slave drives tready.
interface vec_result_fifo_if
    import vec_result_fifo_pkg::*;
#(
    parameter int unsigned SIZE = VEC_SIZE
);
    logic [2:0][SIZE-1:0] tdata;
    logic                 tvalid;
    logic                 tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/vec_result_fifo_credit_counter.sv
// Saturating up/down counter used to track ops in flight.
//   clk, rst_n  : clock, async active-low reset
//   inc, dec    : count up / down; both together leave the value unchanged
//   value       : registered count
//   value_next  : count after this cycle's update
//   err         : sticky, set when dec arrives while the count is zero
module credit_counter
    import vec_result_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] value_next,
    output logic             err
);

    logic [WIDTH-1:0] value_q, value_d;
    logic             err_q, err_d;

    always_comb begin
        value_d = value_q;
        err_d   = err_q;
        // A dec at zero is flagged even if an inc lands in the same cycle.
        if (dec && (value_q == '0)) begin
            err_d = 1'b1;
        end
        if (inc && !dec) begin
            if (value_q != '1) begin
                value_d = value_q + WIDTH'(1);
            end
        end else if (dec && !inc) begin
            if (value_q != '0) begin
                value_d = value_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
            err_q   <= 1'b0;
        end else begin
            value_q <= value_d;
            err_q   <= err_d;
        end
    end

    assign value      = value_q;
    assign value_next = value_d;
    assign err        = err_q;

endmodule

// File: rtl/vec_result_fifo.sv
// Credit-managed result buffer behind vec_mul. Captures result vectors,
// re-presents them first-word-fall-through, and grants issue credit only
// while a FIFO slot is guaranteed for every op still in the multiplier.
//   aclk, aresetn  : clock, async active-low reset
//   issue          : upstream launched one op into vec_mul this cycle
//   issue_ok       : credit available (registered)
//   s_axis         : result beats from vec_mul (slave)
//   m_axis         : buffered beats to the consumer (master)
//   count          : FIFO occupancy
//   err_overflow   : sticky, issue while issue_ok low
//   err_unexpected : sticky, beat accepted with nothing in flight
module vec_result_fifo
    import vec_result_fifo_pkg::*;
#(
    parameter int unsigned SIZE    = VEC_SIZE,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned LATENCY = FMUL_LATENCY
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   issue,
    output logic                   issue_ok,
    vec_result_fifo_if.slave       s_axis,
    vec_result_fifo_if.master      m_axis,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err_overflow,
    output logic                   err_unexpected
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    if (!is_pow2(DEPTH) || (DEPTH < LATENCY + 1)) begin : g_bad_depth
        $error("vec_result_fifo: DEPTH must be a power of 2 and >= LATENCY+1");
    end

    logic [2:0][SIZE-1:0] mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          issue_ok_q, issue_ok_d;
    logic          err_overflow_q, err_overflow_d;

    logic          full, empty, push, pop, issue_acc;
    logic [PW-1:0] fill_next;
    logic [PW-1:0] inflight, inflight_next;
    logic [PW:0]   occupancy_next;

    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    assign s_axis.tready = !full;
    assign m_axis.tvalid = !empty;
    assign m_axis.tdata  = mem_q[rd_ptr_q[AW-1:0]];

    assign push      = s_axis.tvalid && !full;
    assign pop       = !empty && m_axis.tready;
    assign issue_acc = issue && issue_ok_q;

    credit_counter #(
        .WIDTH (PW)
    ) u_inflight (
        .clk        (aclk),
        .rst_n      (aresetn),
        .inc        (issue_acc),
        .dec        (push),
        .value      (inflight),
        .value_next (inflight_next),
        .err        (err_unexpected)
    );

    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        err_overflow_d = err_overflow_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (issue && !issue_ok_q) begin
            err_overflow_d = 1'b1;
        end
        // Credit is granted from next-state occupancy so a slot is reserved
        // for every op that may still be inside the multiplier.
        fill_next      = wr_ptr_d - rd_ptr_d;
        occupancy_next = {1'b0, fill_next} + {1'b0, inflight_next};
        issue_ok_d     = occupancy_next < (PW+1)'(DEPTH);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            issue_ok_q     <= 1'b1;
            err_overflow_q <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            issue_ok_q     <= issue_ok_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge aclk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= s_axis.tdata;
        end
    end

    assign count        = wr_ptr_q - rd_ptr_q;
    assign issue_ok     = issue_ok_q;
    assign err_overflow = err_overflow_q;

    logic unused_inflight;
    assign unused_inflight = ^inflight;

endmodule

// File: tb/tb_vec_result_fifo.sv
module tb_vec_result_fifo;
    import vec_result_fifo_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned LAT   = FMUL_LATENCY;
    localparam int unsigned SIZE  = 32;

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic       issue = 1'b0;
    logic       issue_ok;
    logic [4:0] count;
    logic       err_overflow, err_unexpected;

    vec_result_fifo_if #(.SIZE(SIZE)) s_if ();
    vec_result_fifo_if #(.SIZE(SIZE)) m_if ();

    vec_result_fifo #(
        .SIZE    (SIZE),
        .DEPTH   (DEPTH),
        .LATENCY (LAT)
    ) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .issue          (issue),
        .issue_ok       (issue_ok),
        .s_axis         (s_if.slave),
        .m_axis         (m_if.master),
        .count          (count),
        .err_overflow   (err_overflow),
        .err_unexpected (err_unexpected)
    );

    always #5 aclk = ~aclk;

    // Reference: FIFO contents as a queue, in-flight ops as an integer,
    // vec_mul as a LAT-deep delay line of accepted issues.
    logic [95:0]  q[$];
    int unsigned  infl;
    bit           ok_m, ovf_m, unx_m;
    bit           sr_v[LAT];
    logic [95:0]  sr_d[LAT];
    int           n_checks = 0;
    int           n_err = 0;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] rnd();
        return {$urandom, $urandom, $urandom};
    endfunction

    function automatic void model_reset();
        q.delete();
        infl  = 0;
        ok_m  = 1'b1;
        ovf_m = 1'b0;
        unx_m = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            sr_v[i] = 1'b0;
            sr_d[i] = '0;
        end
    endfunction

    task automatic check_outputs();
        chk("count", 96'(count), 96'(q.size()));
        chk("m_tvalid", 96'(m_if.tvalid), 96'(q.size() != 0));
        chk("s_tready", 96'(s_if.tready), 96'(q.size() < DEPTH));
        chk("issue_ok", 96'(issue_ok), 96'(ok_m));
        chk("err_overflow", 96'(err_overflow), 96'(ovf_m));
        chk("err_unexpected", 96'(err_unexpected), 96'(unx_m));
        if (q.size() != 0) chk("m_tdata", m_if.tdata, q[0]);
    endtask

    // One clock: drive inputs, advance the model across the edge, compare.
    task automatic cycle(input bit iss, input logic [95:0] idata, input bit rdy,
                         input bit xpush, input logic [95:0] xdata);
        bit          tv, push_m, pop_m, acc;
        logic [95:0] td;
        tv = sr_v[LAT-1] | xpush;
        td = xpush ? xdata : sr_d[LAT-1];
        issue       = iss;
        s_if.tvalid = tv;
        s_if.tdata  = td;
        m_if.tready = rdy;
        @(posedge aclk);
        #1;
        push_m = tv && (q.size() < DEPTH);
        pop_m  = rdy && (q.size() != 0);
        acc    = iss && ok_m;
        if (iss && !ok_m) ovf_m = 1'b1;
        if (push_m && infl == 0) unx_m = 1'b1;
        if (pop_m) void'(q.pop_front());
        if (push_m) q.push_back(td);
        if (acc && !push_m) infl++;
        else if (push_m && !acc && infl > 0) infl--;
        ok_m = (q.size() + infl) < DEPTH;
        for (int i = LAT - 1; i > 0; i--) begin
            sr_v[i] = sr_v[i-1];
            sr_d[i] = sr_d[i-1];
        end
        sr_v[0] = acc;
        sr_d[0] = idata;
        check_outputs();
    endtask

    task automatic idle(input bit rdy);
        cycle(1'b0, '0, rdy, 1'b0, '0);
    endtask

    task automatic full_reset();
        aresetn     = 1'b0;
        issue       = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        m_if.tready = 1'b0;
        model_reset();
        repeat (2) @(posedge aclk);
        #1;
        check_outputs();
        aresetn = 1'b1;
    endtask

    initial begin
        int          n_iss, pairs, guard;
        int unsigned seq;
        bit          b, r;

        // Reset state
        full_reset();

        // 1: single op, result 9 cycles later
        cycle(1'b1, rnd(), 1'b0, 1'b0, '0);
        repeat (LAT) idle(1'b0);
        chk("t1_count", 96'(count), 96'd1);
        chk("t1_tvalid", 96'(m_if.tvalid), 96'd1);
        chk("t1_issue_ok", 96'(issue_ok), 96'd1);
        idle(1'b1);

        // 2: stalled consumer, issue whenever credit is offered
        n_iss = 0;
        for (int i = 0; i < 40; i++) begin
            b = issue_ok;
            if (b) n_iss++;
            cycle(b, rnd(), 1'b0, 1'b0, '0);
        end
        chk("t2_issues", 96'(n_iss), 96'd16);
        chk("t2_count", 96'(count), 96'd16);
        chk("t2_tready", 96'(s_if.tready), 96'd0);

        // 3: one pop from full restores credit
        idle(1'b1);
        chk("t3_count", 96'(count), 96'd15);
        chk("t3_issue_ok", 96'(issue_ok), 96'd1);

        // 4: simultaneous push/pop at count 7 across pointer wrap
        guard = 0;
        while (q.size() > 7 && guard < 50) begin
            idle(1'b1);
            guard++;
        end
        chk("t4_prefill", 96'(count), 96'd7);
        pairs = 0;
        guard = 0;
        seq   = 0;
        while (pairs < 20 && guard < 200) begin
            b = issue_ok;
            r = sr_v[LAT-1];
            cycle(b, {seq[31:0], seq[31:0] + 32'd1, seq[31:0] + 32'd2}, r, 1'b0, '0);
            if (b) seq++;
            if (r) begin
                pairs++;
                chk("t4_count", 96'(count), 96'd7);
            end
            guard++;
        end
        chk("t4_pairs", 96'(pairs), 96'd20);

        // 5: illegal issue, then an orphan beat
        guard = 0;
        while (issue_ok && guard < 40) begin
            cycle(1'b1, rnd(), 1'b0, 1'b0, '0);
            guard++;
        end
        chk("t5_credit_gone", 96'(issue_ok), 96'd0);
        cycle(1'b1, rnd(), 1'b0, 1'b0, '0);
        chk("t5_err_overflow", 96'(err_overflow), 96'd1);
        repeat (LAT + 3) idle(1'b0);
        repeat (3) idle(1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1, rnd());
        chk("t5_err_unexpected", 96'(err_unexpected), 96'd1);
        idle(1'b0);
        chk("t5_ovf_sticky", 96'(err_overflow), 96'd1);
        chk("t5_unx_sticky", 96'(err_unexpected), 96'd1);

        // 6: reset mid-stream at count=5, inflight=3
        full_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, rnd(), 1'b0, 1'b0, '0);
        guard = 0;
        while (q.size() < 5 && guard < 30) begin
            idle(1'b0);
            guard++;
        end
        chk("t6_pre_count", 96'(count), 96'd5);
        #2;
        aresetn = 1'b0;
        #1;
        chk("t6_rst_count", 96'(count), 96'd0);
        chk("t6_rst_tvalid", 96'(m_if.tvalid), 96'd0);
        chk("t6_rst_tready", 96'(s_if.tready), 96'd1);
        chk("t6_rst_issue_ok", 96'(issue_ok), 96'd1);
        chk("t6_rst_errs", 96'({err_overflow, err_unexpected}), 96'd0);
        model_reset();
        issue       = 1'b0;
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b0;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        idle(1'b0);
        chk("t6_post_issue_ok", 96'(issue_ok), 96'd1);
        chk("t6_post_count", 96'(count), 96'd0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            b = issue_ok && ($urandom_range(3) != 0);
            r = $urandom_range(1) == 1;
            cycle(b, rnd(), r, 1'b0, '0);
        end
        repeat (LAT + DEPTH + 4) idle(1'b1);
        chk("rand_drained", 96'(count), 96'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
